// File: rtl/nand4_rr_arbiter_if.sv
// Request/response bundle between four requesters, one consumer and the arbiter.
interface nand4_rr_arbiter_if;
    logic [3:0]  req;
    logic [15:0] ops;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_data;
    logic        rsp_ack;
    logic        busy;
    logic        drop;

    modport master (
        output req, ops, rsp_ack,
        input  gnt, rsp_valid, rsp_id, rsp_data, busy, drop
    );

    modport slave (
        input  req, ops, rsp_ack,
        output gnt, rsp_valid, rsp_id, rsp_data, busy, drop
    );
endinterface

// File: rtl/nand4_rr_arbiter.sv
// Round-robin arbiter over four requesters; the winner's 4-bit operand is reduced
// by a NAND and held as a response until acknowledged or timed out.
module nand4_rr_arbiter #(
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    nand4_rr_arbiter_if.slave  bus
);
    localparam int unsigned N    = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 4;
    // Out-of-range limits saturate at the counter's reach.
    localparam logic [CNTW-1:0] LIMIT = (WAIT_LIMIT > 15) ? CNTW'(15) : CNTW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    win_q, win_d;
    logic [OPW-1:0]    opnd_q, opnd_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [N-1:0]      gnt_q, gnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic              rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    logic [IDW-1:0]    pick_c;
    logic              any_c;
    logic              timeout_c;

    // First set request at or above ptr, wrapping; scanned downward so the nearest wins.
    always_comb begin
        pick_c = ptr_q;
        any_c  = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (bus.req[ptr_q + IDW'(k)]) begin
                pick_c = ptr_q + IDW'(k);
                any_c  = 1'b1;
            end
        end
    end

    assign timeout_c = (state_q == RESP) && !bus.rsp_ack && (LIMIT != '0)
                       && (cnt_q == LIMIT - CNTW'(1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    win_d   = pick_c;
                    opnd_d  = bus.ops[{pick_c, 2'b00} +: OPW];
                    state_d = EVAL;
                end
            end
            EVAL: begin
                cnt_d   = '0;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ack || timeout_c) begin
                    state_d = IDLE;
                    ptr_d   = win_q + IDW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_data_d  = 1'b0;
        busy_d      = (state_d != IDLE);
        drop_d      = timeout_c;
        if (state_d == EVAL) begin
            gnt_d = N'(1) << win_d;
        end
        if (state_d == RESP) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_d;
            rsp_data_d  = ~&opnd_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;
endmodule

// File: doc/nand4_rr_arbiter.md
NAND4_RR_ARBITER -- requirements
Module: nand4_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter WAIT_LIMIT, default 8, SHALL set the maximum number of RESP cycles to wait for rsp_ack; 0 disables the timeout.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: req  input  4  request bits, one per requester; bit i belongs to requester i.
REQ-006 Port: ops  input  16  operands; ops[4i+3:4i] = {a,b,c,d} of requester i, with a at bit 4i+3.
REQ-007 Port: gnt  output  4  one-hot grant.
REQ-008 Port: rsp_valid  output  1  result available.
REQ-009 Port: rsp_id  output  2  index of the requester owning the result.
REQ-010 Port: rsp_data  output  1  4-input NAND of the granted operand, ~(a&b&c&d).
REQ-011 Port: rsp_ack  input  1  consumer accepts the result.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: drop  output  1  one-cycle pulse when a result is discarded on timeout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EVAL and RESP.
REQ-015 IDLE, req==0: the FSM SHALL stay in IDLE with all outputs except drop at 0.
REQ-016 IDLE, req!=0: the FSM SHALL select the first set req bit searching from ptr upward, mod 4.
REQ-017 On that selection, the FSM SHALL latch that requester's 4-bit operand and 2-bit index and go to EVAL.
REQ-018 In EVAL, gnt SHALL be one-hot on the winner for exactly one cycle.
REQ-019 In EVAL, the block SHALL register rsp_data = ~&operand, set rsp_id = winner, and go to RESP.
REQ-020 Latency: req sampled at edge k SHALL give gnt high in cycle k+1 and rsp_valid high from cycle k+2.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_id and rsp_data SHALL be held stable until leaving RESP.
REQ-022 RESP with rsp_ack=1 at an edge (including the first RESP cycle) SHALL return to IDLE; rsp_valid SHALL be 0 the next cycle.
REQ-023 On leaving RESP by any path, ptr SHALL become (winner+1) mod 4.
REQ-024 The minimum transaction is 3 cycles: IDLE, EVAL, then RESP with immediate ack; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-025 req changes after the IDLE selection edge SHALL NOT affect the latched operand, rsp_id or rsp_data.
REQ-026 rsp_ack SHALL be ignored outside RESP.
REQ-027 Timeout counting: a 4-bit counter SHALL count RESP cycles without ack.
REQ-028 Timeout: when WAIT_LIMIT>0 and rsp_valid has been high WAIT_LIMIT cycles with no ack, the FSM SHALL return to IDLE and assert drop for exactly the first IDLE cycle.
REQ-029 rsp_ack high on the last allowed RESP cycle SHALL take precedence over timeout: no drop.
REQ-030 WAIT_LIMIT SHALL be limited to 0..15.
REQ-031 Under continuous requests from all four requesters, grants SHALL rotate 0,1,2,3,0; no requester SHALL wait more than 3 other grants.

Reset
REQ-032 reset=1 at an edge SHALL force state IDLE and ptr=0, and SHALL clear the counter, latched operand and index.
REQ-033 After a reset edge, gnt, rsp_valid, rsp_id, rsp_data, busy and drop SHALL all be 0 in the following cycle, regardless of prior state, including mid-EVAL or mid-RESP.
REQ-034 reset SHALL take priority over rsp_ack and req in the same cycle; a transaction in flight SHALL be discarded without a drop pulse.

Verification
REQ-035 After reset, req=4'b0100 with ops[11:8]=4'b1111 -> gnt=4'b0100 in cycle 1; rsp_valid=1, rsp_id=2, rsp_data=0 in cycle 2.
REQ-036 With req=4'b1111 held, ops all 4'b1010 and rsp_ack tied high -> gnt sequence 0001,0010,0100,1000,0001 every 3 cycles; rsp_data=1 each time.
REQ-037 For requester 0, drive all 16 operand values -> rsp_data=0 only for ops[3:0]=4'b1111, 1 otherwise.
REQ-038 With WAIT_LIMIT=8 and rsp_ack held low -> rsp_valid high exactly 8 cycles, one-cycle drop, busy=0, and the next grant goes to requester winner+1.
REQ-039 Reset during RESP while rsp_ack=1 -> all outputs 0 the next cycle, no drop; a subsequent req=4'b1001 is granted to requester 0.
REQ-040 rsp_ack pulsed in IDLE and EVAL -> no state change, and rsp_valid still asserts in the expected cycle.
